// File: rtl/sobel_pkg.sv
// Shared widths and helpers for the Sobel edge detector.
// sat_u8 clamps an 11-bit magnitude sum to the 8-bit pixel range.
package sobel_pkg;

  localparam int SOBEL_SUM_W  = 10;
  localparam int SOBEL_DIFF_W = 11;
  localparam int SOBEL_MAG_W  = 8;
  localparam int PIPE_LAT     = 3;

  function automatic logic [SOBEL_MAG_W-1:0] sat_u8(input logic [SOBEL_DIFF_W-1:0] v);
    return (v > 11'd255) ? 8'hFF : v[SOBEL_MAG_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_axis_grad.sv
// One Sobel axis: weighted sums of the positive and negative tap triples (stage 1),
// then the absolute difference (stage 2). 2-cycle latency, no backpressure.
module sobel_axis_grad
  import sobel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_de,
  input  logic                   s1_de,
  input  logic [7:0]             p0,
  input  logic [7:0]             p1,
  input  logic [7:0]             p2,
  input  logic [7:0]             n0,
  input  logic [7:0]             n1,
  input  logic [7:0]             n2,
  output logic [SOBEL_SUM_W-1:0] grad_abs
);

  logic [SOBEL_SUM_W-1:0]  pos_c, neg_c, pos_q, neg_q, abs_c;
  logic [SOBEL_DIFF_W-1:0] diff_c;

  assign pos_c  = {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
  assign neg_c  = {2'b00, n0} + {1'b0, n1, 1'b0} + {2'b00, n2};
  // two's-complement difference; the low 10 bits of the negation suffice since |diff| <= 1020
  assign diff_c = {1'b0, pos_q} - {1'b0, neg_q};
  assign abs_c  = diff_c[SOBEL_DIFF_W-1] ? (~diff_c[SOBEL_SUM_W-1:0] + 10'd1)
                                         : diff_c[SOBEL_SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      neg_q    <= '0;
      grad_abs <= '0;
    end else begin
      pos_q    <= in_de ? pos_c : '0;
      neg_q    <= in_de ? neg_c : '0;
      grad_abs <= s1_de ? abs_c : '0;
    end
  end

endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel L1 magnitude and thresholded edge pixel, 3-cycle fixed latency, no stalls.
// Optional SOBEL_BORDER_EN zeroes the outermost ring of pixels of each frame.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter logic [10:0] IMG_WIDTH      = 11'd1920,
  parameter logic [10:0] IMG_HEIGHT     = 11'd1080,
  parameter logic [7:0]  THRESH_DEFAULT = 8'd128
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       matrix_vs,
  input  logic       matrix_de,
  input  logic [7:0] matrix11,
  input  logic [7:0] matrix12,
  input  logic [7:0] matrix13,
  input  logic [7:0] matrix21,
  input  logic [7:0] matrix22,
  input  logic [7:0] matrix23,
  input  logic [7:0] matrix31,
  input  logic [7:0] matrix32,
  input  logic [7:0] matrix33,
  input  logic [7:0] edge_thresh,
  output logic       sobel_vs,
  output logic       sobel_de,
  output logic [7:0] sobel_mag,
  output logic [7:0] sobel_data
);

  logic                   de_s1, de_s2, vs_s1, vs_s2, vs_rise, border;
  logic [7:0]             thresh_act, mag_c, edge_c;
  logic [SOBEL_SUM_W-1:0] gx_abs, gy_abs;

  // center tap does not contribute to either kernel
  logic [7:0] unused_center;
  assign unused_center = matrix22;

  sobel_axis_grad u_gx (
    .clk(video_clk), .rst_n(rst_n), .in_de(matrix_de), .s1_de(de_s1),
    .p0(matrix13), .p1(matrix23), .p2(matrix33),
    .n0(matrix11), .n1(matrix21), .n2(matrix31),
    .grad_abs(gx_abs)
  );

  sobel_axis_grad u_gy (
    .clk(video_clk), .rst_n(rst_n), .in_de(matrix_de), .s1_de(de_s1),
    .p0(matrix31), .p1(matrix32), .p2(matrix33),
    .n0(matrix11), .n1(matrix12), .n2(matrix13),
    .grad_abs(gy_abs)
  );

  // vs_s1 doubles as the previous-cycle matrix_vs for edge detection
  assign vs_rise = matrix_vs & ~vs_s1;
  assign mag_c   = sat_u8({1'b0, gx_abs} + {1'b0, gy_abs});
  assign edge_c  = (mag_c >= thresh_act) ? 8'hFF : 8'h00;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1      <= 1'b0;
      de_s2      <= 1'b0;
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      sobel_de   <= 1'b0;
      sobel_vs   <= 1'b0;
      sobel_mag  <= 8'h00;
      sobel_data <= 8'h00;
      thresh_act <= THRESH_DEFAULT;
    end else begin
      de_s1    <= matrix_de;
      de_s2    <= de_s1;
      vs_s1    <= matrix_vs;
      vs_s2    <= vs_s1;
      sobel_de <= de_s2;
      sobel_vs <= vs_s2;
      if (vs_rise) thresh_act <= edge_thresh;
      if (de_s2 && !border) begin
        sobel_mag  <= mag_c;
        sobel_data <= edge_c;
      end else begin
        sobel_mag  <= 8'h00;
        sobel_data <= 8'h00;
      end
    end
  end

`ifdef SOBEL_BORDER_EN
  logic [10:0] x_cnt, y_cnt;

  // counters describe the pixel currently entering stage 3
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= de_s2 ? x_cnt + 11'd1 : 11'd0;
      if (vs_rise)
        y_cnt <= '0;
      else if (sobel_de && !de_s2)
        y_cnt <= y_cnt + 11'd1;
    end
  end

  assign border = (x_cnt == 11'd0) || (x_cnt == IMG_WIDTH - 11'd1) ||
                  (y_cnt == 11'd0) || (y_cnt == IMG_HEIGHT - 11'd1);
`else
  logic [21:0] unused_dims;
  assign unused_dims = {IMG_WIDTH, IMG_HEIGHT};
  assign border      = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect: inputs driven on falling edges, outputs sampled there.
module tb_sobel_edge_detect;

  logic       video_clk = 1'b0;
  logic       rst_n, matrix_vs, matrix_de;
  logic [7:0] matrix11, matrix12, matrix13, matrix21, matrix22, matrix23;
  logic [7:0] matrix31, matrix32, matrix33, edge_thresh;
  logic       sobel_vs, sobel_de;
  logic [7:0] sobel_mag, sobel_data;

  int checks   = 0;
  int failures = 0;
  int ox, oy, nde;
  logic prev_de;

  always #5 video_clk = ~video_clk;

  sobel_edge_detect #(.IMG_WIDTH(11'd8), .IMG_HEIGHT(11'd4), .THRESH_DEFAULT(8'd128)) dut (
    .video_clk(video_clk), .rst_n(rst_n), .matrix_vs(matrix_vs), .matrix_de(matrix_de),
    .matrix11(matrix11), .matrix12(matrix12), .matrix13(matrix13),
    .matrix21(matrix21), .matrix22(matrix22), .matrix23(matrix23),
    .matrix31(matrix31), .matrix32(matrix32), .matrix33(matrix33),
    .edge_thresh(edge_thresh), .sobel_vs(sobel_vs), .sobel_de(sobel_de),
    .sobel_mag(sobel_mag), .sobel_data(sobel_data)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge video_clk);
  endtask

  task automatic set_cols(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    matrix11 = c1; matrix21 = c1; matrix31 = c1;
    matrix12 = c2; matrix22 = c2; matrix32 = c2;
    matrix13 = c3; matrix23 = c3; matrix33 = c3;
  endtask

  task automatic set_rows(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    matrix11 = r1; matrix12 = r1; matrix13 = r1;
    matrix21 = r2; matrix22 = r2; matrix23 = r2;
    matrix31 = r3; matrix32 = r3; matrix33 = r3;
  endtask

  task automatic vs_pulse(input logic [7:0] th);
    edge_thresh = th;
    matrix_vs   = 1'b1;
    cyc();
    matrix_vs   = 1'b0;
    cyc();
  endtask

  // tracks output raster position from sobel_de alone and checks the border rule
  task automatic collect6(input int n);
    logic [7:0] exp;
    repeat (n) begin
      cyc();
      if (sobel_de) begin
`ifdef SOBEL_BORDER_EN
        exp = (ox == 0 || ox == 7 || oy == 0 || oy == 3) ? 8'h00 : 8'hFF;
`else
        exp = 8'hFF;
`endif
        check($sformatf("t6_px_x%0d_y%0d", ox, oy), sobel_data, exp);
        ox++;
        nde++;
      end else if (prev_de) begin
        oy++;
        ox = 0;
      end
      prev_de = sobel_de;
    end
  endtask

  localparam logic [4:0] DE_PAT = 5'b01011; // slot0 in bit0: 1,1,0,1,0

  initial begin
    rst_n = 1'b0; matrix_vs = 1'b0; matrix_de = 1'b0; edge_thresh = 8'd0;
    set_cols(8'd0, 8'd0, 8'd0);
    cyc(2);
    check("rst_de", sobel_de, 1'b0);
    check("rst_mag", sobel_mag, 8'd0);
    check("rst_data", sobel_data, 8'd0);
    rst_n = 1'b1;
    cyc();
    vs_pulse(8'd128);

`ifndef SOBEL_BORDER_EN
    // flat window and de latency
    set_cols(8'd100, 8'd100, 8'd100);
    matrix_de = 1'b1;
    cyc(); check("t1_de_c1", sobel_de, 1'b0);
    cyc(); check("t1_de_c2", sobel_de, 1'b0);
    cyc(); check("t1_de_c3", sobel_de, 1'b1);
    check("t1_mag", sobel_mag, 8'd0);
    check("t1_data", sobel_data, 8'h00);

    // strong vertical edge, saturating
    set_cols(8'd0, 8'd0, 8'd255);
    cyc(2); check("t2_lat", sobel_mag, 8'd0);
    cyc();  check("t2_mag", sobel_mag, 8'd255);
    check("t2_data", sobel_data, 8'hFF);

    set_cols(8'd0, 8'd0, 8'd63);  cyc(3); check("sat_252", sobel_mag, 8'd252);
    set_cols(8'd0, 8'd0, 8'd64);  cyc(3); check("sat_256", sobel_mag, 8'd255);
    set_cols(8'd50, 8'd50, 8'd0); cyc(3); check("neg_gx", sobel_mag, 8'd200);
    set_rows(8'd0, 8'd0, 8'd50);  cyc(3); check("gy_only", sobel_mag, 8'd200);
    set_cols(8'd0, 8'd0, 8'd0); matrix33 = 8'd100;
    cyc(3); check("gx_plus_gy", sobel_mag, 8'd200);

    // weak edge around threshold 100/101
    matrix_de = 1'b0;
    vs_pulse(8'd100);
    set_cols(8'd0, 8'd0, 8'd25); matrix_de = 1'b1;
    cyc(3); check("t3_mag", sobel_mag, 8'd100);
    check("t3_eq_thresh", sobel_data, 8'hFF);
    vs_pulse(8'd101);
    cyc(3); check("t3_above", sobel_data, 8'h00);

    // mid-frame threshold change only takes effect at next vs rise
    vs_pulse(8'd128);
    set_cols(8'd0, 8'd0, 8'd50);
    cyc(3); check("t4_pre", sobel_data, 8'hFF);
    edge_thresh = 8'd255;
    cyc(5); check("t4_hold", sobel_data, 8'hFF);
    matrix_vs = 1'b1; cyc(); matrix_vs = 1'b0; cyc(2);
    check("t4_post", sobel_data, 8'h00);
    check("t4_post_mag", sobel_mag, 8'd200);

    // threshold 0 flags every valid pixel
    vs_pulse(8'd0);
    set_cols(8'd100, 8'd100, 8'd100);
    cyc(3); check("thresh0", sobel_data, 8'hFF);

    // de gaps
    vs_pulse(8'd128);
    matrix_de = 1'b0;
    cyc(4);
    set_cols(8'd0, 8'd0, 8'd50);
    for (int i = 0; i < 8; i++) begin
      matrix_de = (i < 5) ? DE_PAT[i] : 1'b0;
      cyc();
      if (i >= 2) begin
        check($sformatf("t5_de_%0d", i - 2), sobel_de, DE_PAT[i-2]);
        check($sformatf("t5_mag_%0d", i - 2), sobel_mag, DE_PAT[i-2] ? 8'd200 : 8'd0);
        check($sformatf("t5_data_%0d", i - 2), sobel_data, DE_PAT[i-2] ? 8'hFF : 8'h00);
      end
    end

    // asynchronous reset mid-line, threshold returns to default
    vs_pulse(8'd50);
    set_cols(8'd0, 8'd0, 8'd25); matrix_de = 1'b1;
    cyc(4); check("rst_pre", sobel_data, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_de", sobel_de, 1'b0);
    check("rst_mid_mag", sobel_mag, 8'd0);
    check("rst_mid_data", sobel_data, 8'h00);
    cyc();
    rst_n = 1'b1;
    cyc(3); check("rst_thr_mag", sobel_mag, 8'd100);
    check("rst_thr_data", sobel_data, 8'h00);
    set_cols(8'd0, 8'd0, 8'd32);
    cyc(3); check("rst_thr_eq", sobel_data, 8'hFF);
`endif

    // 8x4 frame, every window Gx=1020
    matrix_de = 1'b0;
    cyc(4);
    vs_pulse(8'd128);
    cyc(2);
    set_cols(8'd0, 8'd0, 8'd255);
    ox = 0; oy = 0; nde = 0; prev_de = 1'b0;
    for (int ln = 0; ln < 4; ln++) begin
      matrix_de = 1'b1;
      for (int px = 0; px < 8; px++) collect6(1);
      matrix_de = 1'b0;
      collect6(3);
    end
    collect6(4);
    check("t6_count", nde[15:0], 16'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
